dfp_sig_addsub_seq: RTL and testbench
=====================================

Name: dfp_sig_addsub_seq

Overview:
- Digit-serial BCD significand adder/subtractor for the DFP add/sub datapath. Default width is the DFP128 34-digit coefficient.
- Processes DPC digits per cycle, LSB first, and uses ten's-complement subtraction with serial re-complement when the result is negative.
- Has a valid/ready request/response handshake, so a sequencer can trade area for latency.
- Sits between exponent alignment (upstream) and rounding/normalisation (downstream).

Parameters:
- NDIG, 34, significand digits; must be a multiple of DPC.
- DPC, 2, BCD digits processed per cycle; 1..NDIG.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; 0 freezes all state and outputs
- req_valid  in  1  operand request valid
- req_ready  out  1  block can accept a request
- op  in  1  0 = add, 1 = subtract
- sa  in  1  sign of a
- a  in  4*NDIG  BCD magnitude a, aligned
- sb  in  1  sign of b
- b  in  4*NDIG  BCD magnitude b, aligned
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- o  out  4*NDIG  BCD result magnitude
- so  out  1  result sign
- cout  out  1  decimal carry out of MSD (effective add only)
- zero  out  1  result magnitude is all zeros
- invalid  out  1  non-BCD input nibble detected (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; req_ready=1, rsp_valid=0.
  - o=0, so=0, cout=0, zero=0, invalid=0; digit counter=0, carry=0.
- Reset mid-operation: aborts immediately; no response is ever produced for the aborted request.
- Effective subtract: es = op ^ sa ^ sb.
- States: IDLE, RUN, FIX, DONE. All transitions are qualified by ce=1.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch a, b, sa, es; clear counter; carry = es.
  - Go to RUN.
- RUN:
  - Each cycle processes digits [k*DPC +: DPC], k = 0..NDIG/DPC-1.
  - Per digit: s = a_d + (es ? 9-b_d : b_d) + c.
  - If s>9: digit = s-10 (mod 16 correction), c=1; else digit = s, c=0.
  - Ripple c through the DPC digits within the cycle.
  - After the last group:
    - es=0: cout=c, so=sa; go to DONE.
    - es=1, c=1: |a|>=|b|; so=sa, cout=0; go to DONE.
    - es=1, c=0: |a|<|b|; clear counter, set carry=1, cout=0; go to FIX.
- FIX:
  - Serial ten's complement of o over NDIG/DPC cycles: digit = (9-d)+c with the same correction.
  - so=~sa; go to DONE.
- DONE:
  - rsp_valid=1; outputs are held stable while rsp_valid=1 && rsp_ready=0.
  - On rsp_ready: go to IDLE, rsp_valid=0.
  - req_ready is 0 in RUN, FIX and DONE. No request overlap; a new request is accepted the cycle after the response handshake.
- zero = (o==0), valid with rsp_valid. If zero and es=1, so is forced to 0.
- Latency, accept edge to rsp_valid high, with ce held 1:
  - NDIG/DPC cycles without FIX.
  - 2*NDIG/DPC cycles with FIX.
- ce=0 in any state: no state, counter, carry or output change; handshakes are not recognised.
- req_valid is ignored outside IDLE. rsp_ready is ignored outside DONE.

Optional Feature:
- Macro: DFP_SIG_BCD_CHECK_EN.
- Defined: at request accept, invalid is latched = 1 if any nibble of a or b is >9. It is reported alongside rsp_valid and cleared on the next accept. The arithmetic result is still produced (mod-16 behaviour, not specified).
- Not defined: invalid is tied to 0 and no check logic is built.

Test Plan (NDIG=34, DPC=2, ce=1, rsp_ready=1 unless stated):
- Add: a=7, b=2, op=0, sa=sb=0 -> o=9, so=0, cout=0, zero=0; rsp_valid 17 cycles after accept.
- Negative subtract: a=2, b=7, op=1, sa=sb=0 -> FIX path; o=5, so=1; rsp_valid 34 cycles after accept.
- Carry out: a=all 9s (34 digits), b=1, op=0 -> o=0, cout=1, zero=1, so=0.
- Exact cancel: a=b=5, sa=1, sb=1, op=1 -> o=0, zero=1, so=0 (forced); 17-cycle latency.
- Back-pressure/stall: hold rsp_ready=0 for 5 cycles -> o/so/rsp_valid stable and req_ready=0. Then drop ce for 3 cycles mid-RUN of a new request -> latency extends by exactly 3.
- Reset abort: assert rst_n=0 during the 8th RUN cycle -> outputs immediately at reset values. The next request (a=1, b=1, add) returns o=2 with normal latency. With DFP_SIG_BCD_CHECK_EN, a nibble 0xA in a -> invalid=1.

Source files
------------

// File: rtl/dfp_sig_addsub_seq.sv
// -----------------------------------------------------------------------------
// dfp_sig_addsub_seq
//   Digit-serial BCD significand adder/subtractor for the DFP add/sub path.
//   Processes DPC BCD digits per cycle, LSB group first. Effective subtract
//   uses ten's-complement addition; a negative result (no final carry) is
//   re-complemented serially in a second pass (FIX) and the sign flipped.
//
//   Optional build macro: DFP_SIG_BCD_CHECK_EN
//     defined   : invalid latches "any nibble of a or b > 9" at request accept
//     undefined : invalid tied to 0, no check logic
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ce                  clock enable, 0 freezes all state and outputs
//   req_valid/req_ready operand request handshake (op, sa, a, sb, b)
//   rsp_valid/rsp_ready result handshake (o, so, cout, zero, invalid)
//   o                   BCD result magnitude, 4*NDIG bits
//   so                  result sign (forced 0 for a zero effective-subtract result)
//   cout                decimal carry out of MSD, effective add only
//   zero                result magnitude is all zeros
//   invalid             non-BCD input nibble seen (optional feature)
// -----------------------------------------------------------------------------
module dfp_sig_addsub_seq #(
  parameter int NDIG = 34,
  parameter int DPC  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              op,
  input  logic              sa,
  input  logic [4*NDIG-1:0] a,
  input  logic              sb,
  input  logic [4*NDIG-1:0] b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [4*NDIG-1:0] o,
  output logic              so,
  output logic              cout,
  output logic              zero,
  output logic              invalid
);

  localparam int NGRP = NDIG / DPC;
  localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int GW   = 4 * DPC;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t              state_q;
  logic [4*NDIG-1:0]   a_q, b_q, o_q;
  logic                sa_q, es_q, carry_q;
  logic [CW-1:0]       cnt_q;
  logic                so_q, cout_q, zero_q;
  logic                req_ready_q, rsp_valid_q;

  // Group datapath
  logic [GW-1:0]       grp_a, grp_b, grp_o, grp_sum;
  logic [3:0]          dx, dy;
  logic [4:0]          s;
  logic                c;
  logic                grp_c;
  logic [4*NDIG-1:0]   o_d;
  logic                o_zero;
  logic                last_grp;
  logic                es_in;

  assign es_in    = op ^ sa ^ sb;
  assign last_grp = (cnt_q == CW'(NGRP - 1));

  // One digit group per cycle. In RUN the operands are a and (b or 9-b);
  // in FIX the same adder forms (9-o)+carry to re-complement the result.
  always_comb begin
    grp_a   = a_q[int'(cnt_q)*GW +: GW];
    grp_b   = b_q[int'(cnt_q)*GW +: GW];
    grp_o   = o_q[int'(cnt_q)*GW +: GW];
    grp_sum = '0;
    dx      = '0;
    dy      = '0;
    s       = '0;
    c       = carry_q;
    for (int unsigned i = 0; i < DPC; i++) begin
      if (state_q == FIX) begin
        dx = 4'd9 - grp_o[i*4 +: 4];
        dy = 4'd0;
      end else begin
        dx = grp_a[i*4 +: 4];
        dy = es_q ? (4'd9 - grp_b[i*4 +: 4]) : grp_b[i*4 +: 4];
      end
      s = {1'b0, dx} + {1'b0, dy} + {4'b0, c};
      if (s > 5'd9) begin
        grp_sum[i*4 +: 4] = s[3:0] - 4'd10;
        c = 1'b1;
      end else begin
        grp_sum[i*4 +: 4] = s[3:0];
        c = 1'b0;
      end
    end
    grp_c = c;
    o_d   = o_q;
    o_d[int'(cnt_q)*GW +: GW] = grp_sum;
    o_zero = (o_d == '0);
  end

`ifdef DFP_SIG_BCD_CHECK_EN
  logic invalid_q;

  function automatic logic has_non_bcd(input logic [4*NDIG-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      invalid_q <= 1'b0;
    end else if (ce && state_q == IDLE && req_valid) begin
      invalid_q <= has_non_bcd(a) | has_non_bcd(b);
    end
  end

  assign invalid = invalid_q;
`else
  assign invalid = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      o_q         <= '0;
      sa_q        <= 1'b0;
      es_q        <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      so_q        <= 1'b0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else if (ce) begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            a_q         <= a;
            b_q         <= b;
            sa_q        <= sa;
            es_q        <= es_in;
            carry_q     <= es_in;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            state_q     <= RUN;
          end
        end
        RUN: begin
          o_q     <= o_d;
          carry_q <= grp_c;
          if (last_grp) begin
            if (!es_q) begin
              cout_q      <= grp_c;
              so_q        <= sa_q;
              zero_q      <= o_zero;
              rsp_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (grp_c) begin
              // |a| >= |b|: ten's-complement sum is already the magnitude
              cout_q      <= 1'b0;
              so_q        <= o_zero ? 1'b0 : sa_q;
              zero_q      <= o_zero;
              rsp_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              // |a| < |b|: second pass re-complements o
              cout_q  <= 1'b0;
              cnt_q   <= '0;
              carry_q <= 1'b1;
              state_q <= FIX;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        FIX: begin
          o_q     <= o_d;
          carry_q <= grp_c;
          if (last_grp) begin
            so_q        <= o_zero ? 1'b0 : ~sa_q;
            zero_q      <= o_zero;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign o         = o_q;
  assign so        = so_q;
  assign cout      = cout_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_dfp_sig_addsub_seq.sv
module tb_dfp_sig_addsub_seq;

  localparam int NDIG = 34;
  localparam int DPC  = 2;
  localparam int W    = 4 * NDIG;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ce = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         op = 1'b0, sa = 1'b0, sb = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] o;
  logic         so, cout, zero, invalid;

  dfp_sig_addsub_seq #(.NDIG(NDIG), .DPC(DPC)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .sa(sa), .a(a), .sb(sb), .b(b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .o(o), .so(so), .cout(cout), .zero(zero), .invalid(invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         op, sa, sb;
    logic [W-1:0] a, b;
    logic [W-1:0] eo;
    logic         eso, ecout, ezero, einv;
    int           lat;
    bit           chk_data;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];
  int   acc_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_cyc = 0;
  int n_rsp = 0;
  logic rv_prev = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no event expected one within bound", name);
  endtask

  function automatic vec_t mk(input logic op_, input logic sa_, input logic [W-1:0] a_,
                              input logic sb_, input logic [W-1:0] b_, input logic [W-1:0] eo_,
                              input logic eso_, input logic ecout_, input logic ezero_, input int lat_);
    vec_t v;
    v.op = op_; v.sa = sa_; v.a = a_; v.sb = sb_; v.b = b_;
    v.eo = eo_; v.eso = eso_; v.ecout = ecout_; v.ezero = ezero_;
    v.einv = 1'b0; v.lat = lat_; v.chk_data = 1'b1;
    return v;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: records accepts, latency of rsp_valid rise, and scores responses.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      acc_q.delete();
      rv_prev = 1'b0;
    end else begin
      if (ce && req_valid && req_ready) acc_q.push_back(cyc + 1);
      if (rsp_valid && !rv_prev) first_cyc = cyc;
      rv_prev = rsp_valid;
      if (ce && rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0 || acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got response o=%h expected none", o);
        end else begin
          vec_t e;
          int   acc;
          e   = sb_q.pop_front();
          acc = acc_q.pop_front();
          if (e.chk_data) begin
            chk("o", o, e.eo);
            chk("so", W'(so), W'(e.eso));
            chk("cout", W'(cout), W'(e.ecout));
            chk("zero", W'(zero), W'(e.ezero));
          end
          chk("invalid", W'(invalid), W'(e.einv));
          chk("latency", W'(first_cyc - acc), W'(e.lat));
        end
        n_rsp++;
      end
    end
  end

  task automatic send(input vec_t v);
    bit ok;
    @(posedge clk); #1;
    op = v.op; sa = v.sa; sb = v.sb; a = v.a; b = v.b;
    req_valid = 1'b1;
    sb_q.push_back(v);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (req_ready && ce) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!ok) begin
      void'(sb_q.pop_back());
      fail_timeout("req_accept");
    end
  endtask

  task automatic wait_rsp(input int target);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (n_rsp >= target) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("rsp_wait");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit   ok;
    logic [W-1:0] nines, top6, top7, top3, top1, low33n, zw;

    zw     = '0;
    nines  = {NDIG{4'h9}};
    top6   = {4'h6, zw[W-5:0]};
    top7   = {4'h7, zw[W-5:0]};
    top3   = {4'h3, zw[W-5:0]};
    top1   = {4'h1, zw[W-5:0]};
    low33n = {4'h0, nines[W-5:0]};

    //          op sa a            sb b            o             so cout zero lat
    tbl.push_back(mk(0, 0, W'('h7),    0, W'('h2),     W'('h9),     0, 0, 0, 17));
    tbl.push_back(mk(1, 0, W'('h2),    0, W'('h7),     W'('h5),     1, 0, 0, 34));
    tbl.push_back(mk(0, 0, nines,      0, W'('h1),     zw,          0, 1, 1, 17));
    tbl.push_back(mk(1, 1, W'('h5),    1, W'('h5),     zw,          0, 0, 1, 17));
    tbl.push_back(mk(0, 1, W'('h1234), 0, W'('h766),   W'('h468),   1, 0, 0, 17));
    tbl.push_back(mk(1, 0, W'('h100),  1, W'('h1),     W'('h101),   0, 0, 0, 17));
    tbl.push_back(mk(0, 0, W'('h5),    1, W'('h12345), W'('h12340), 1, 0, 0, 34));
    tbl.push_back(mk(0, 1, zw,         1, zw,          zw,          1, 0, 1, 17));
    tbl.push_back(mk(0, 0, top6,       0, top7,        top3,        0, 1, 0, 17));
    tbl.push_back(mk(1, 0, top1,       0, W'('h1),     low33n,      0, 0, 0, 17));

    // Reset state
    #12;
    chk("rst_rsp_valid", W'(rsp_valid), W'(0));
    chk("rst_req_ready", W'(req_ready), W'(1));
    chk("rst_o", o, zw);
    chk("rst_so", W'(so), W'(0));
    chk("rst_cout", W'(cout), W'(0));
    chk("rst_zero", W'(zero), W'(0));
    chk("rst_invalid", W'(invalid), W'(0));
    @(negedge clk); rst_n = 1'b1;

    // Table vectors
    foreach (tbl[i]) begin
      int target;
      target = n_rsp + 1;
      send(tbl[i]);
      wait_rsp(target);
    end

    // Back-pressure: result held while rsp_ready=0
    rsp_ready = 1'b0;
    v = mk(0, 0, W'('h7), 0, W'('h2), W'('h9), 0, 0, 0, 17);
    send(v);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("bp_rsp_valid");
    for (int t = 0; t < 5; t++) begin
      chk("bp_hold", {rsp_valid, req_ready, so, o},
          {1'b1, 1'b0, 1'b0, W'('h9)});
      @(negedge clk);
    end
    begin
      int target;
      target = n_rsp + 1;
      @(posedge clk); #1 rsp_ready = 1'b1;
      wait_rsp(target);
    end

    // ce stall mid-RUN stretches latency by the frozen cycles
    begin
      int target;
      target = n_rsp + 1;
      v = mk(0, 0, W'('h38), 0, W'('h45), W'('h83), 0, 0, 0, 20);
      send(v);
      repeat (4) @(posedge clk);
      #1 ce = 1'b0;
      repeat (3) @(posedge clk);
      #1 ce = 1'b1;
      wait_rsp(target);
    end

    // Reset abort in the 8th RUN cycle
    begin
      int target;
      v = mk(0, 0, W'('h7), 0, W'('h2), W'('h9), 0, 0, 0, 17);
      send(v);
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_rsp_valid", W'(rsp_valid), W'(0));
      chk("abort_req_ready", W'(req_ready), W'(1));
      chk("abort_o", o, zw);
      chk("abort_flags", W'({so, cout, zero, invalid}), W'(0));
      @(negedge clk);
      @(negedge clk); rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("abort_no_rsp", W'(rsp_valid), W'(0));
      target = n_rsp + 1;
      v = mk(0, 0, W'('h1), 0, W'('h1), W'('h2), 0, 0, 0, 17);
      send(v);
      wait_rsp(target);
    end

`ifdef DFP_SIG_BCD_CHECK_EN
    begin
      int target;
      target = n_rsp + 1;
      v = mk(0, 0, W'('hA), 0, W'('h1), zw, 0, 0, 0, 17);
      v.einv = 1'b1;
      v.chk_data = 1'b0;
      send(v);
      wait_rsp(target);
      target = n_rsp + 1;
      v = mk(0, 0, W'('h7), 0, W'('h2), W'('h9), 0, 0, 0, 17);
      send(v);
      wait_rsp(target);
    end
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
